// File: rtl/framebuffer_row_reader.sv
// ---------------------------------------------------------------------------
// framebuffer_row_reader
//
// Read-side scan engine for the dual-port framebuffer RAM. A row request
// makes the block walk the 16-bit read port across one display row
// (2^COL_BITS pixels). A 2-entry skid buffer absorbs the RAM's one-cycle read
// latency. RGB565 pixels stream to the panel shifter over a valid/ready
// handshake.
//
// Optional feature macro: FBREAD_BLANK_EN
//   When defined, an extra input Blank is sampled together with ReqRow. A
//   blanked row issues no RAM reads. It streams 2^COL_BITS zero pixels with
//   the same timing and handshake as a normal row.
//
// Ports
//   Clock      in   sole clock, rising edge
//   ResetN     in   asynchronous active-low reset
//   ReqValid   in   row request valid
//   ReqRow     in   row index, sampled on accept
//   Blank      in   (FBREAD_BLANK_EN only) blank the requested row
//   ReqReady   out  high only while idle
//   RamAddr    out  read address {row, col}; zero when no read is issued
//   RamClockEn out  read strobe; RamData is valid on the following cycle
//   RamData    in   read data
//   PixValid   out  pixel available
//   PixData    out  RGB565 pixel (head of the skid buffer)
//   PixLast    out  high with the final pixel of the row
//   PixReady   in   downstream ready
//   RowDone    out  one-cycle pulse after the last pixel is accepted
//   dbg_state  out  current FSM state (0 idle, 1 fetch, 2 drain)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. While valid is high and ready is low, the source holds valid and
// data stable. ReqValid/ReqReady and PixValid/PixReady both follow this rule.
// ---------------------------------------------------------------------------
module framebuffer_row_reader #(
  parameter int ROW_BITS = 5,
  parameter int COL_BITS = 6
) (
  input  logic                         Clock,
  input  logic                         ResetN,
  input  logic                         ReqValid,
  input  logic [ROW_BITS-1:0]          ReqRow,
`ifdef FBREAD_BLANK_EN
  input  logic                         Blank,
`endif
  output logic                         ReqReady,
  output logic [ROW_BITS+COL_BITS-1:0] RamAddr,
  output logic                         RamClockEn,
  input  logic [15:0]                  RamData,
  output logic                         PixValid,
  output logic [15:0]                  PixData,
  output logic                         PixLast,
  input  logic                         PixReady,
  output logic                         RowDone,
  output logic [1:0]                   dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [COL_BITS-1:0] COL_LAST = '1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e              state_q,     state_d;
  logic [ROW_BITS-1:0] row_q,       row_d;
  logic [COL_BITS-1:0] issue_col_q, issue_col_d;
  logic [COL_BITS-1:0] out_col_q,   out_col_d;
  logic                rd_pend_q,   rd_pend_d;   // a read was issued last cycle
  logic [15:0]         fifo_mem_q [2];
  logic [15:0]         fifo_mem_d [2];
  logic                wr_ptr_q,    wr_ptr_d;
  logic                rd_ptr_q,    rd_ptr_d;
  logic [1:0]          count_q,     count_d;     // entries held in fifo_mem_q
  logic                row_done_q,  row_done_d;
`ifdef FBREAD_BLANK_EN
  logic                blank_q,     blank_d;
`endif

  // -------------------------------------------------------------------------
  // Datapath helpers
  // -------------------------------------------------------------------------
  logic        blank_row;
  logic [15:0] ret_data;
  logic [1:0]  fifo_level;
  logic        issue;
  logic        pix_valid;
  logic [15:0] head_data;
  logic        pop;
  logic        pop_stored;
  logic        push;

`ifdef FBREAD_BLANK_EN
  assign blank_row = blank_q;
`else
  assign blank_row = 1'b0;
`endif

  always_comb begin
    // A blanked row still runs the issue/return pipeline. Only the RAM
    // strobe is suppressed, and the returned word is forced to black.
    // This keeps blanked-row timing identical to a normal row.
    ret_data = blank_row ? 16'h0000 : RamData;

    // The logical FIFO holds the stored entries plus the word returning from
    // the RAM this cycle. The returning word is visible at the output
    // straight away. Without this, the first pixel would land at T+3.
    fifo_level = count_q + {1'b0, rd_pend_q};

    // Credit rule: stored entries plus in-flight reads must stay below two.
    issue = (state_q == ST_FETCH) && (fifo_level < 2'd2);

    pix_valid = (fifo_level != 2'd0);
    if (count_q != 2'd0) begin
      head_data = fifo_mem_q[rd_ptr_q];
    end else if (rd_pend_q) begin
      head_data = ret_data;
    end else begin
      head_data = 16'h0000;
    end

    pop        = pix_valid & PixReady;
    // With nothing stored, a pop consumes the returning word directly and
    // that word never enters the storage.
    pop_stored = pop & (count_q != 2'd0);
    push       = rd_pend_q & ~(pop & (count_q == 2'd0));
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    issue_col_d   = issue_col_q;
    out_col_d     = out_col_q;
    rd_pend_d     = issue;
    fifo_mem_d[0] = fifo_mem_q[0];
    fifo_mem_d[1] = fifo_mem_q[1];
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q + {1'b0, push} - {1'b0, pop_stored};
    row_done_d    = 1'b0;
`ifdef FBREAD_BLANK_EN
    blank_d       = blank_q;
`endif

    if (push) begin
      fifo_mem_d[wr_ptr_q] = ret_data;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop_stored) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (issue) begin
      issue_col_d = issue_col_q + 1'b1;
    end
    if (pop) begin
      out_col_d = out_col_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (ReqValid) begin
          state_d     = ST_FETCH;
          row_d       = ReqRow;
          issue_col_d = '0;
          out_col_d   = '0;
`ifdef FBREAD_BLANK_EN
          blank_d     = Blank;
`endif
        end
      end
      ST_FETCH: begin
        // The issue counter wraps to zero here. That value is never used,
        // because the next accept clears the counter again.
        if (issue && (issue_col_q == COL_LAST)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // RowDone is high for one cycle in DRAIN. Idle (and ReqReady)
        // follows on the next cycle.
        if (row_done_q) begin
          state_d = ST_IDLE;
        end else if (pop && (out_col_q == COL_LAST)) begin
          row_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers. A reset aborts any row in progress and discards any read in
  // flight.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q       <= ST_IDLE;
      row_q         <= '0;
      issue_col_q   <= '0;
      out_col_q     <= '0;
      rd_pend_q     <= 1'b0;
      fifo_mem_q[0] <= 16'h0000;
      fifo_mem_q[1] <= 16'h0000;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      row_done_q    <= 1'b0;
`ifdef FBREAD_BLANK_EN
      blank_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      issue_col_q   <= issue_col_d;
      out_col_q     <= out_col_d;
      rd_pend_q     <= rd_pend_d;
      fifo_mem_q[0] <= fifo_mem_d[0];
      fifo_mem_q[1] <= fifo_mem_d[1];
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      row_done_q    <= row_done_d;
`ifdef FBREAD_BLANK_EN
      blank_q       <= blank_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Each output is a function of flops only; no input reaches an
  // output combinationally except RamData, through the skid-buffer bypass.
  // -------------------------------------------------------------------------
  always_comb begin
    ReqReady   = (state_q == ST_IDLE);
    RamClockEn = issue & ~blank_row;
    RamAddr    = RamClockEn ? {row_q, issue_col_q} : '0;
    PixValid   = pix_valid;
    PixData    = head_data;
    PixLast    = pix_valid & (out_col_q == COL_LAST);
    RowDone    = row_done_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_framebuffer_row_reader.sv
// ---------------------------------------------------------------------------
// Bench for framebuffer_row_reader.
//
// A row-level model keeps the pixels each accepted row must deliver in a
// queue. It also tracks idle/busy, the expected RowDone pulse and the read
// order. A compare process checks the DUT against the model on every falling
// edge. Directed sections add literal expectations for the key cycle
// timings.
// ---------------------------------------------------------------------------
module tb_framebuffer_row_reader;

  localparam int ROW_BITS = 5;
  localparam int COL_BITS = 6;
  localparam int NPIX     = 64;

  // ---------------------------------------------------------------- signals
  logic        Clock;
  logic        ResetN;
  logic        ReqValid;
  logic [4:0]  ReqRow;
  logic        ReqReady;
  logic [10:0] RamAddr;
  logic        RamClockEn;
  logic [15:0] RamData;
  logic        PixValid;
  logic [15:0] PixData;
  logic        PixLast;
  logic        PixReady;
  logic        RowDone;
  logic [1:0]  dbg_state;
`ifdef FBREAD_BLANK_EN
  logic        Blank;
`endif

  int checks;
  int errors;

  framebuffer_row_reader #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS)) dut (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .ReqValid   (ReqValid),
    .ReqRow     (ReqRow),
`ifdef FBREAD_BLANK_EN
    .Blank      (Blank),
`endif
    .ReqReady   (ReqReady),
    .RamAddr    (RamAddr),
    .RamClockEn (RamClockEn),
    .RamData    (RamData),
    .PixValid   (PixValid),
    .PixData    (PixData),
    .PixLast    (PixLast),
    .PixReady   (PixReady),
    .RowDone    (RowDone),
    .dbg_state  (dbg_state)
  );

  // ------------------------------------------------------- clock and reset
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  // RAM model: each word holds its own address. Without a strobe the data
  // port carries junk, so a DUT that uses stale data gets caught.
  always @(posedge Clock) begin
    if (RamClockEn) RamData <= {5'b0, RamAddr};
    else            RamData <= 16'($urandom);
  end

  // ---------------------------------------------------------------- checker
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ model state
  logic [15:0] exp_q[$];   // pixels still owed for the current row
  bit          m_idle;
  bit          m_done;     // RowDone expected this cycle
  bit          m_blank;
  logic [4:0]  m_row;
  int          iss_n;      // reads seen this row
  int          pop_n;      // pixels accepted this row

  initial begin
    m_idle  = 1'b1;
    m_done  = 1'b0;
    m_blank = 1'b0;
    m_row   = '0;
    iss_n   = 0;
    pop_n   = 0;
    checks  = 0;
    errors  = 0;
  end

  always @(negedge Clock) begin
    bit done_next;
    if (!ResetN) begin
      chk("rst_req_ready",  ReqReady,   1);
      chk("rst_ram_en",     RamClockEn, 0);
      chk("rst_ram_addr",   RamAddr,    0);
      chk("rst_pix_valid",  PixValid,   0);
      chk("rst_pix_data",   PixData,    0);
      chk("rst_pix_last",   PixLast,    0);
      chk("rst_row_done",   RowDone,    0);
      exp_q.delete();
      m_idle  = 1'b1;
      m_done  = 1'b0;
      m_blank = 1'b0;
      iss_n   = 0;
      pop_n   = 0;
    end else begin
      chk("req_ready", ReqReady, m_idle);
      chk("row_done",  RowDone,  m_done);
      if (m_done) begin
        chk("row_issue_count", iss_n, m_blank ? 0 : NPIX);
        chk("row_pop_count",   pop_n, NPIX);
      end

      // Reads must follow column order, only while a RAM-backed row is
      // active, with at most two outstanding.
      if (RamClockEn) begin
        if (m_idle || m_blank || iss_n >= NPIX) begin
          chk("ram_en_unexpected", RamClockEn, 0);
        end else begin
          chk("ram_addr", RamAddr, {m_row, 6'(iss_n)});
          chk("outstanding_le2", ((iss_n + 1 - pop_n) <= 2) ? 1 : 0, 1);
          iss_n++;
        end
      end

      if (PixValid) begin
        if (exp_q.size() == 0) begin
          chk("pix_unexpected", PixValid, 0);
        end else begin
          chk("pix_data", PixData, exp_q[0]);
          chk("pix_last", PixLast, (exp_q.size() == 1) ? 1 : 0);
        end
      end else begin
        chk("pix_last_no_valid", PixLast, 0);
      end

      done_next = 1'b0;
      if (PixValid && PixReady && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        pop_n++;
        if (exp_q.size() == 0) done_next = 1'b1;
      end

      if (m_idle && ReqValid) begin
        m_idle = 1'b0;
        m_row  = ReqRow;
`ifdef FBREAD_BLANK_EN
        m_blank = Blank;
`else
        m_blank = 1'b0;
`endif
        iss_n = 0;
        pop_n = 0;
        for (int c = 0; c < NPIX; c++) begin
          exp_q.push_back(m_blank ? 16'h0000 : {5'b0, m_row, 6'(c)});
        end
      end else if (m_done) begin
        m_idle = 1'b1;
      end
      m_done = done_next;
    end
  end

  // ------------------------------------------------------------ driver tasks
  task automatic request(input logic [4:0] row);
    @(posedge Clock); #1;
    ReqValid = 1'b1;
    ReqRow   = row;
    @(posedge Clock); #1;
    ReqValid = 1'b0;
  endtask

  // Waits for RowDone (bounded). Optionally drives PixReady low ~30% of
  // the cycles.
  task automatic wait_done(input string nm, input bit rnd_ready);
    int n;
    n = 0;
    do begin
      @(posedge Clock); #1;
      if (rnd_ready) PixReady = ($urandom_range(0, 99) >= 30);
      @(negedge Clock);
      n++;
    end while (!RowDone && n < 2000);
    chk(nm, RowDone, 1);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int n;
    ResetN   = 1'b0;
    ReqValid = 1'b0;
    ReqRow   = '0;
    PixReady = 1'b0;
`ifdef FBREAD_BLANK_EN
    Blank    = 1'b0;
`endif
    repeat (3) @(posedge Clock);
    #1 ResetN = 1'b1;

    // Reset then idle for 100 cycles.
    PixReady = 1'b1;
    repeat (100) @(negedge Clock);
    chk("idle_req_ready", ReqReady, 1);
    chk("idle_pix_valid", PixValid, 0);

    // Full-rate row 3, with cycle-exact timing.
    @(posedge Clock); #1;
    ReqValid = 1'b1;
    ReqRow   = 5'd3;
    @(negedge Clock);                         // T: accepted
    @(posedge Clock); #1 ReqValid = 1'b0;
    @(negedge Clock);                         // T+1
    chk("model_head",     exp_q[0],    16'h00C0);
    chk("model_size",     exp_q.size(), 64);
    chk("first_ram_en",   RamClockEn,  1);
    chk("first_ram_addr", RamAddr,     11'h0C0);
    chk("t1_pix_valid",   PixValid,    0);
    @(negedge Clock);                         // T+2
    chk("first_pix_valid", PixValid, 1);
    chk("first_pix_data",  PixData,  16'h00C0);
    repeat (63) @(negedge Clock);             // T+65
    chk("last_pix_valid", PixValid, 1);
    chk("last_pix_last",  PixLast,  1);
    chk("last_pix_data",  PixData,  16'h00FF);
    @(negedge Clock);                         // T+66
    chk("full_row_done",  RowDone,  1);
    chk("done_req_ready", ReqReady, 0);
    @(negedge Clock);                         // T+67
    chk("next_req_ready", ReqReady, 1);
    chk("after_row_done", RowDone,  0);

    // Backpressure on row 31.
    request(5'd31);
    wait_done("bp_row_done", 1'b1);
    PixReady = 1'b1;
    repeat (3) @(negedge Clock);

    // Request held high while the row ReqRow changes mid-row.
    @(posedge Clock); #1;
    ReqValid = 1'b1;
    ReqRow   = 5'd7;
    n = 0;
    do begin
      @(posedge Clock); #1;
      ReqRow = 5'($urandom_range(0, 31));
      @(negedge Clock);
      n++;
    end while (!RowDone && n < 2000);
    chk("ign_row_done", RowDone, 1);
    @(posedge Clock); #1 ReqRow = 5'd9;
    @(negedge Clock);                         // cycle after RowDone
    chk("second_req_ready", ReqReady, 1);
    @(posedge Clock); #1 ReqValid = 1'b0;
    @(negedge Clock);
    chk("second_busy", ReqReady, 0);
    wait_done("second_row_done", 1'b0);
    repeat (3) @(negedge Clock);

    // Reset pulse after 10 pixels of row 12.
    request(5'd12);
    n = 0;
    while (pop_n < 10 && n < 500) begin
      @(posedge Clock);
      n++;
    end
    chk("mid_pops_reached", (pop_n >= 10) ? 1 : 0, 1);
    #1 ResetN = 1'b0;
    @(negedge Clock);
    chk("mid_rst_pix_valid", PixValid, 0);
    chk("mid_rst_req_ready", ReqReady, 1);
    @(posedge Clock); #1 ResetN = 1'b1;
    repeat (5) @(negedge Clock);
    chk("post_rst_row_done", RowDone, 0);
    request(5'd0);
    wait_done("row0_done", 1'b0);
    repeat (3) @(negedge Clock);

`ifdef FBREAD_BLANK_EN
    // Blanked row 5.
    Blank = 1'b1;
    request(5'd5);
    Blank = 1'b0;
    wait_done("blank_row_done", 1'b0);
    repeat (3) @(negedge Clock);
`endif

    chk("final_req_ready", ReqReady, 1);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
